imem_boot_loader: RTL and testbench
===================================

// Module: imem_boot_loader
// PURPOSE
//  Serial program loader and run sequencer for the pipelined RISC-V core.
//  Takes a byte stream (valid/ready) and frames it with SOF/EOF/ESC codes.
//  Packs bytes little-endian into 32-bit words and writes them to instruction
//  memory, then raises start_o to release PC and pipeline registers.
//  Replaces the ad-hoc 0xFE/0xFF flag logic at the core top level.
// PARAMETERS
//  ADDR_W      6     instruction memory word-address width
//  IMEM_WORDS  64    words available; must be <= 2**ADDR_W
//  TIMEOUT_CYC 1024  idle cycles before mid-word abort (only with LOADER_TIMEOUT_EN)
// PORTS
//  clk_i           in  1         clock, rising edge
//  reset_n         in  1         reset; one clock; asynchronous, active-low
//  byte_valid_i    in  1         byte_i is valid
//  byte_i          in  8         stream byte
//  byte_ready_o    out 1         loader accepts byte this cycle
//  imem_we_o       out 1         instruction memory write request
//  imem_addr_o     out ADDR_W    word address of the write
//  imem_wdata_o    out 32        packed instruction word
//  imem_ready_i    in  1         memory accepts write this cycle
//  halt_i          in  1         stop the core and return to IDLE
//  start_o         out 1         core run enable (drives PC/pipeline start_i)
//  err_o           out 1         framing or overflow error, sticky until next SOF
//  loaded_words_o  out ADDR_W+1  words written by the current/last load
//  state_o         out 3         current FSM state encoding, for debug
// BEHAVIOUR
//  Reset (async): state IDLE; all outputs 0 except byte_ready_o=1; counters 0.
//  Byte accepted = byte_valid_i & byte_ready_o at the clock edge.
//  Codes: SOF=8'hFE, EOF=8'hFF, ESC=8'hFD. The byte after ESC is always data.
//  FSM states: IDLE, LOAD, WRITE, RUN, ERROR.
//  IDLE:  ready=1. SOF -> LOAD with addr=0, byte_cnt=0, loaded_words=0. Other bytes ignored.
//  LOAD:  ready=1.
//    - Data byte goes to lane byte_cnt; the first byte fills [7:0].
//    - On the 4th byte -> WRITE.
//    - EOF with byte_cnt==0 -> RUN. EOF with byte_cnt!=0 -> ERROR (partial word).
//    - SOF -> restart the load: addr, byte_cnt and loaded_words cleared.
//    - ESC sets the escape flag. ESC+byte at lane 3 still goes to WRITE.
//    - Data byte with addr==IMEM_WORDS -> ERROR (overflow).
//  WRITE: ready=0. imem_we_o=1; addr and wdata are held stable until imem_ready_i.
//    - On accept: addr+1, loaded_words+1, byte_cnt=0 -> LOAD. we drops next cycle.
//    - Latency: 4th byte accepted at edge N -> imem_we_o high in cycle N+1.
//  RUN:   start_o=1, ready=1.
//    - halt_i -> IDLE with start_o=0 next cycle.
//    - SOF -> LOAD with start_o=0. halt_i has priority over SOF in the same cycle.
//    - Other bytes ignored.
//  ERROR: err_o=1, start_o=0, ready=1. Only SOF leaves -> LOAD, clearing err_o.
//  halt_i in LOAD/WRITE: abort to IDLE. An in-flight write is dropped.
//  loaded_words_o holds its value through RUN and IDLE until the next SOF.
//  Escape flag clears on SOF, EOF, error or reset. ESC followed by ESC gives literal FD.
// CONFIGURATION
//  LOADER_TIMEOUT_EN defined:
//    - Cycle counter clears on each accepted byte in LOAD.
//    - Reaching TIMEOUT_CYC with byte_cnt!=0 or escape pending -> ERROR.
//    - No timeout applies at a word boundary.
//  Not defined: no counter; LOAD waits indefinitely.
// STRUCTURE
//  Package boot_loader_pkg contains:
//    - state typedef (3-bit)
//    - SOF/EOF/ESC byte constants
//    - a function for lane insertion
//  One sub-module, byte_word_packer:
//    - lane counter, escape flag, 32-bit shift/assemble register, word_valid pulse
//    - ack input clears the counter
// TESTING
//  1 SOF, 8 data bytes 01..08, EOF, imem_ready_i tied 1
//    -> writes 0x04030201@0 and 0x08070605@1; loaded_words=2; start_o=1.
//  2 Hold imem_ready_i low for 5 cycles during WRITE
//    -> byte_ready_o=0 and addr/wdata stable for the full stall; one write only.
//  3 SOF, 3 bytes, EOF -> err_o=1, start_o=0. A following SOF clears err_o.
//  4 SOF, then ESC,FF,ESC,FE,ESC,FD,00, then EOF -> word 0x00FDFEFF@0; RUN.
//  5 IMEM_WORDS=4: SOF, 16 bytes, 1 more data byte -> 4 writes then err_o=1.
//    The same load ending in EOF after 16 bytes instead -> RUN.
//  6 In RUN, halt_i and SOF in the same cycle -> IDLE, start_o=0.
//    Assert reset_n low mid-WRITE -> outputs at reset values immediately.
//    With LOADER_TIMEOUT_EN: stall mid-word -> ERROR after TIMEOUT_CYC cycles.

Source files
------------

// File: rtl/boot_loader_pkg.sv
// Shared types, stream codes and lane helper for the instruction-memory boot loader.
package boot_loader_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned CNT_W   = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_WRITE = 3'd2,
    ST_RUN   = 3'd3,
    ST_ERROR = 3'd4
  } state_t;

  localparam logic [BYTE_W-1:0] SOF_CODE = 8'hFE;
  localparam logic [BYTE_W-1:0] EOF_CODE = 8'hFF;
  localparam logic [BYTE_W-1:0] ESC_CODE = 8'hFD;

  // Place one byte into a little-endian lane of a word, leaving other lanes intact.
  function automatic logic [WORD_W-1:0] insert_lane(input logic [WORD_W-1:0] word,
                                                    input logic [1:0]        lane,
                                                    input logic [BYTE_W-1:0] data);
    logic [WORD_W-1:0] res;
    res = word;
    res[{lane, 3'b000} +: BYTE_W] = data;
    return res;
  endfunction

endpackage

// File: rtl/byte_word_packer.sv
// Byte-to-word assembler: lane counter, escape flag and little-endian word register.
module byte_word_packer
  import boot_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              ack,
  input  logic              push,
  input  logic              esc_set,
  input  logic [BYTE_W-1:0] data,
  output logic [CNT_W-1:0]  byte_cnt,
  output logic              esc,
  output logic [WORD_W-1:0] word,
  output logic              word_valid_c
);

  // The pushed byte completes the word when it lands in lane 3.
  assign word_valid_c = push & (byte_cnt == CNT_W'(3));

  // Lane counter, escape flag and word assembly; flush wins over everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt <= '0;
      esc      <= 1'b0;
      word     <= '0;
    end else if (flush) begin
      byte_cnt <= '0;
      esc      <= 1'b0;
    end else if (ack) begin
      byte_cnt <= '0;
    end else if (push) begin
      word     <= insert_lane(word, byte_cnt[1:0], data);
      byte_cnt <= byte_cnt + CNT_W'(1);
      esc      <= 1'b0;
    end else if (esc_set) begin
      esc      <= 1'b1;
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Serial program loader and run sequencer: frames a byte stream, writes packed
// words into instruction memory, then raises start_o to release the core.
// Optional macro LOADER_TIMEOUT_EN aborts a stalled partial word after TIMEOUT_CYC idle cycles.
module imem_boot_loader
  import boot_loader_pkg::*;
#(
  parameter int unsigned ADDR_W      = 6,
  parameter int unsigned IMEM_WORDS  = 64,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic              clk_i,
  input  logic              reset_n,
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_i,
  output logic              byte_ready_o,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_wdata_o,
  input  logic              imem_ready_i,
  input  logic              halt_i,
  output logic              start_o,
  output logic              err_o,
  output logic [ADDR_W:0]   loaded_words_o,
  output logic [2:0]        state_o
);

  localparam int unsigned LW_W = ADDR_W + 1;

  // Reject configurations the address/count registers cannot represent.
  if (IMEM_WORDS > (2 ** ADDR_W) || TIMEOUT_CYC == 0) begin : g_cfg_check
    $error("imem_boot_loader: IMEM_WORDS exceeds address space or TIMEOUT_CYC is zero");
  end

  state_t            state, next_state;
  logic [CNT_W-1:0]  byte_cnt;
  logic              esc;
  logic              word_valid_c;
  logic              acc_c, sof_c, eof_c, esc_code_c, data_c, full_c;
  logic              push_c, esc_set_c, ack_c, restart_c, flush_c, timeout_c;
  logic              ready_d, we_d, start_d, err_d;

  // Byte classification; an escaped byte is always data.
  assign acc_c      = byte_valid_i & byte_ready_o;
  assign sof_c      = acc_c & ~esc & (byte_i == SOF_CODE);
  assign eof_c      = acc_c & ~esc & (byte_i == EOF_CODE);
  assign esc_code_c = acc_c & ~esc & (byte_i == ESC_CODE);
  assign data_c     = acc_c & ~sof_c & ~eof_c & ~esc_code_c;
  // loaded_words tracks addr but is one bit wider, so it can represent a full memory.
  assign full_c     = (loaded_words_o == LW_W'(IMEM_WORDS));

  // Datapath strobes derived from current state and inputs.
  assign push_c    = (state == ST_LOAD) & data_c & ~full_c & ~halt_i;
  assign esc_set_c = (state == ST_LOAD) & esc_code_c & ~halt_i;
  assign ack_c     = (state == ST_WRITE) & imem_ready_i & ~halt_i;
  assign restart_c = sof_c & ~(halt_i & ((state == ST_LOAD) | (state == ST_RUN)));
  assign flush_c   = restart_c | (next_state == ST_IDLE) | (next_state == ST_RUN) |
                     (next_state == ST_ERROR);

`ifdef LOADER_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] idle_cnt;

  // Idle-cycle counter in LOAD; any accepted byte or leaving LOAD restarts it.
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      idle_cnt <= '0;
    end else if ((state == ST_LOAD) && !acc_c) begin
      if (idle_cnt != TO_W'(TIMEOUT_CYC)) idle_cnt <= idle_cnt + TO_W'(1);
    end else begin
      idle_cnt <= '0;
    end
  end

  assign timeout_c = (state == ST_LOAD) & ~acc_c & (idle_cnt == TO_W'(TIMEOUT_CYC)) &
                     ((byte_cnt != '0) | esc);
`else
  assign timeout_c = 1'b0;
`endif

  // State register plus registered Moore outputs decoded from the next state.
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      byte_ready_o <= 1'b1;
      imem_we_o    <= 1'b0;
      start_o      <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      state        <= next_state;
      byte_ready_o <= ready_d;
      imem_we_o    <= we_d;
      start_o      <= start_d;
      err_o        <= err_d;
    end
  end

  // Next-state selection; halt has priority over stream bytes in LOAD/WRITE/RUN.
  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE: begin
        if (sof_c) next_state = ST_LOAD;
      end
      ST_LOAD: begin
        if (halt_i)                 next_state = ST_IDLE;
        else if (timeout_c)         next_state = ST_ERROR;
        else if (sof_c)             next_state = ST_LOAD;
        else if (eof_c)             next_state = (byte_cnt == '0) ? ST_RUN : ST_ERROR;
        else if (data_c && full_c)  next_state = ST_ERROR;
        else if (word_valid_c)      next_state = ST_WRITE;
      end
      ST_WRITE: begin
        if (halt_i)            next_state = ST_IDLE;
        else if (imem_ready_i) next_state = ST_LOAD;
      end
      ST_RUN: begin
        if (halt_i)     next_state = ST_IDLE;
        else if (sof_c) next_state = ST_LOAD;
      end
      ST_ERROR: begin
        if (sof_c) next_state = ST_LOAD;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Output values for the state being entered.
  always_comb begin
    ready_d = 1'b1;
    we_d    = 1'b0;
    start_d = 1'b0;
    err_d   = 1'b0;
    unique case (next_state)
      ST_WRITE: begin
        ready_d = 1'b0;
        we_d    = 1'b1;
      end
      ST_RUN:   start_d = 1'b1;
      ST_ERROR: err_d   = 1'b1;
      default: ;
    endcase
  end

  // Write address and word count: cleared by SOF, advanced on each accepted write.
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      imem_addr_o    <= '0;
      loaded_words_o <= '0;
    end else if (restart_c) begin
      imem_addr_o    <= '0;
      loaded_words_o <= '0;
    end else if (ack_c) begin
      imem_addr_o    <= imem_addr_o + ADDR_W'(1);
      loaded_words_o <= loaded_words_o + LW_W'(1);
    end
  end

  assign state_o = state;

  byte_word_packer u_packer (
    .clk          (clk_i),
    .rst_n        (reset_n),
    .flush        (flush_c),
    .ack          (ack_c),
    .push         (push_c),
    .esc_set      (esc_set_c),
    .data         (byte_i),
    .byte_cnt     (byte_cnt),
    .esc          (esc),
    .word         (imem_wdata_o),
    .word_valid_c (word_valid_c)
  );

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader (IMEM_WORDS=4 so overflow is reachable quickly).
module tb_imem_boot_loader;

  localparam int unsigned ADDR_W      = 6;
  localparam int unsigned IMEM_WORDS  = 4;
  localparam int unsigned TIMEOUT_CYC = 1024;

  logic              clk_i = 1'b0;
  logic              reset_n;
  logic              byte_valid_i;
  logic [7:0]        byte_i;
  logic              byte_ready_o;
  logic              imem_we_o;
  logic [ADDR_W-1:0] imem_addr_o;
  logic [31:0]       imem_wdata_o;
  logic              imem_ready_i;
  logic              halt_i;
  logic              start_o;
  logic              err_o;
  logic [ADDR_W:0]   loaded_words_o;
  logic [2:0]        state_o;

  int checks   = 0;
  int failures = 0;
  int wr_cnt   = 0;
  int base;
  logic [ADDR_W-1:0] log_addr [0:63];
  logic [31:0]       log_data [0:63];

  imem_boot_loader #(
    .ADDR_W      (ADDR_W),
    .IMEM_WORDS  (IMEM_WORDS),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk_i          (clk_i),
    .reset_n        (reset_n),
    .byte_valid_i   (byte_valid_i),
    .byte_i         (byte_i),
    .byte_ready_o   (byte_ready_o),
    .imem_we_o      (imem_we_o),
    .imem_addr_o    (imem_addr_o),
    .imem_wdata_o   (imem_wdata_o),
    .imem_ready_i   (imem_ready_i),
    .halt_i         (halt_i),
    .start_o        (start_o),
    .err_o          (err_o),
    .loaded_words_o (loaded_words_o),
    .state_o        (state_o)
  );

  always #5 clk_i = ~clk_i;

  // Record every write the memory accepts.
  always @(posedge clk_i) begin
    if (reset_n && imem_we_o && imem_ready_i && wr_cnt < 64) begin
      log_addr[wr_cnt] <= imem_addr_o;
      log_data[wr_cnt] <= imem_wdata_o;
      wr_cnt           <= wr_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Present one byte and hold it until the loader takes it (bounded wait).
  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    byte_valid_i = 1'b1;
    byte_i       = b;
    while (!byte_ready_o && n < 40) begin
      tick();
      n++;
    end
    if (!byte_ready_o) chk("send_ready_timeout", 32'(byte_ready_o), 32'd1);
    tick();
    byte_valid_i = 1'b0;
  endtask

  initial begin
    reset_n      = 1'b0;
    byte_valid_i = 1'b0;
    byte_i       = 8'h00;
    imem_ready_i = 1'b1;
    halt_i       = 1'b0;

    // Reset values
    tick();
    chk("rst_ready",  32'(byte_ready_o),   32'd1);
    chk("rst_we",     32'(imem_we_o),      32'd0);
    chk("rst_start",  32'(start_o),        32'd0);
    chk("rst_err",    32'(err_o),          32'd0);
    chk("rst_loaded", 32'(loaded_words_o), 32'd0);
    chk("rst_state",  32'(state_o),        32'd0);
    #3 reset_n = 1'b1;
    tick();

    // 1: two words then EOF
    base = wr_cnt;
    send(8'hFE);
    for (int i = 1; i <= 8; i++) send(8'(i));
    send(8'hFF);
    chk("t1_nwr",    32'(wr_cnt - base),   32'd2);
    chk("t1_addr0",  32'(log_addr[base]),  32'd0);
    chk("t1_data0",  log_data[base],       32'h04030201);
    chk("t1_addr1",  32'(log_addr[base+1]), 32'd1);
    chk("t1_data1",  log_data[base+1],     32'h08070605);
    chk("t1_loaded", 32'(loaded_words_o),  32'd2);
    chk("t1_start",  32'(start_o),         32'd1);
    chk("t1_state",  32'(state_o),         32'd3);

    // 2: memory stall during WRITE
    base = wr_cnt;
    send(8'hFE);
    chk("t2_start_drop", 32'(start_o), 32'd0);
    imem_ready_i = 1'b0;
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    chk("t2_we_lat", 32'(imem_we_o), 32'd1);
    for (int c = 0; c < 5; c++) begin
      chk("t2_stall_ready", 32'(byte_ready_o), 32'd0);
      chk("t2_stall_we",    32'(imem_we_o),    32'd1);
      chk("t2_stall_addr",  32'(imem_addr_o),  32'd0);
      chk("t2_stall_data",  imem_wdata_o,      32'h44332211);
      tick();
    end
    chk("t2_nowr_stall", 32'(wr_cnt - base), 32'd0);
    imem_ready_i = 1'b1;
    tick();
    chk("t2_we_drop", 32'(imem_we_o),      32'd0);
    chk("t2_nwr",     32'(wr_cnt - base),  32'd1);
    chk("t2_loaded",  32'(loaded_words_o), 32'd1);
    send(8'hFF);
    chk("t2_run", 32'(state_o), 32'd3);

    // 3: partial word then EOF
    send(8'hFE);
    send(8'h01); send(8'h02); send(8'h03);
    send(8'hFF);
    chk("t3_err",   32'(err_o),   32'd1);
    chk("t3_start", 32'(start_o), 32'd0);
    chk("t3_state", 32'(state_o), 32'd4);
    send(8'hFE);
    chk("t3_err_clr", 32'(err_o),          32'd0);
    chk("t3_load",    32'(state_o),        32'd1);
    chk("t3_loaded0", 32'(loaded_words_o), 32'd0);

    // 4: escaped codes as data
    base = wr_cnt;
    send(8'hFE);
    send(8'hFD); send(8'hFF);
    send(8'hFD); send(8'hFE);
    send(8'hFD); send(8'hFD);
    send(8'h00);
    send(8'hFF);
    chk("t4_nwr",   32'(wr_cnt - base),  32'd1);
    chk("t4_addr",  32'(log_addr[base]), 32'd0);
    chk("t4_data",  log_data[base],      32'h00FDFEFF);
    chk("t4_state", 32'(state_o),        32'd3);
    chk("t4_start", 32'(start_o),        32'd1);

    // 5: overflow past IMEM_WORDS, then same load ending in EOF
    base = wr_cnt;
    send(8'hFE);
    for (int i = 0; i < 16; i++) send(8'(8'h10 + i));
    send(8'h55);
    chk("t5_nwr",    32'(wr_cnt - base),    32'd4);
    chk("t5_addr3",  32'(log_addr[base+3]), 32'd3);
    chk("t5_data3",  log_data[base+3],      32'h1F1E1D1C);
    chk("t5_err",    32'(err_o),            32'd1);
    chk("t5_state",  32'(state_o),          32'd4);
    send(8'hFE);
    for (int i = 0; i < 16; i++) send(8'(8'h10 + i));
    send(8'hFF);
    chk("t5_run",    32'(state_o),        32'd3);
    chk("t5_loaded", 32'(loaded_words_o), 32'd4);

    // 6a: halt beats SOF in RUN; count held in IDLE
    halt_i       = 1'b1;
    byte_valid_i = 1'b1;
    byte_i       = 8'hFE;
    tick();
    halt_i       = 1'b0;
    byte_valid_i = 1'b0;
    chk("t6_idle",      32'(state_o),        32'd0);
    chk("t6_start",     32'(start_o),        32'd0);
    chk("t6_loaded_hold", 32'(loaded_words_o), 32'd4);

    // 6b: halt mid-word aborts to IDLE
    send(8'hFE); send(8'hA1); send(8'hA2);
    halt_i = 1'b1;
    tick();
    halt_i = 1'b0;
    chk("t6_halt_load", 32'(state_o), 32'd0);

    // 6c: async reset during WRITE
    imem_ready_i = 1'b0;
    send(8'hFE);
    send(8'hB1); send(8'hB2); send(8'hB3); send(8'hB4);
    chk("t6_in_write", 32'(state_o), 32'd2);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_rst_we",     32'(imem_we_o),      32'd0);
    chk("t6_rst_ready",  32'(byte_ready_o),   32'd1);
    chk("t6_rst_state",  32'(state_o),        32'd0);
    chk("t6_rst_addr",   32'(imem_addr_o),    32'd0);
    chk("t6_rst_wdata",  imem_wdata_o,        32'h0);
    chk("t6_rst_loaded", 32'(loaded_words_o), 32'd0);
    #2 reset_n = 1'b1;
    imem_ready_i = 1'b1;
    tick();

`ifdef LOADER_TIMEOUT_EN
    // Timeout on a stalled partial word
    send(8'hFE);
    send(8'h01);
    repeat (TIMEOUT_CYC + 4) tick();
    chk("t6_timeout_err", 32'(err_o), 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
